pos_frame_reader: RTL and testbench
===================================

// Module: pos_frame_reader
// PURPOSE
//  Read-side consumer of the distance/gray point FIFO (32-bit words {gray[15:0], pos[15:0]}).
//  Waits until one complete scan frame is buffered, drains it word by word and emits a framed
//  byte stream (header, count, payload, checksum) through a valid/ready byte interface toward
//  the Nios/UART uplink. Runs entirely in the FIFO read-clock domain.
// PARAMETERS
//  FRAME_POINTS  811    words per scan frame; also the FIFO level required to start a frame
//  USEDW_W       11     width of the FIFO used-words count
//  HDR0          8'hAA  first header byte
//  HDR1          8'h55  second header byte
// PORTS
//  clk          in   1        FIFO read clock; all logic on rising edge
//  rst          in   1        asynchronous, active-low reset
//  enable       in   1        allows new frames to start; sampled only in IDLE
//  fifo_usedw   in   USEDW_W  FIFO read-side used-words count
//  fifo_rdreq   out  1        FIFO read request; rddata is valid 1 cycle after the request
//  fifo_rddata  in   32       FIFO data: [31:16] gray, [15:0] pos
//  tx_data      out  8        outgoing byte
//  tx_valid     out  1        tx_data valid; a byte transfers when tx_valid & tx_ready
//  tx_ready     in   1        downstream accepts byte
//  busy         out  1        high from frame start until return to IDLE
//  frame_done   out  1        1-cycle pulse after the checksum byte transfers
//  frame_err    out  1        1-cycle pulse on frame abort (FIFO ran dry mid-frame)
//  frame_cnt    out  16       completed frames; wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: fifo_rdreq=0, tx_valid=0, tx_data=0, busy=0, frame_done=0, frame_err=0, frame_cnt=0; FSM=IDLE.
//  States: IDLE -> HDR (4 bytes) -> RDREQ -> RDWAIT -> SEND (4 bytes) -> {RDREQ | CHK} -> IDLE.
//  IDLE: go to HDR when enable && fifo_usedw >= FRAME_POINTS (at that cycle's sample).
//  HDR: send HDR0, HDR1, FRAME_POINTS[15:8], FRAME_POINTS[7:0] in that order.
//  RDREQ: if fifo_usedw==0 -> pulse frame_err, go to IDLE (no checksum; frame_cnt unchanged);
//    otherwise assert fifo_rdreq for exactly 1 cycle. RDWAIT: latch fifo_rddata on the next cycle.
//  SEND: pos[15:8], pos[7:0], gray[15:8], gray[7:0]; then RDREQ if fewer than FRAME_POINTS
//    words are consumed, else CHK.
//  CHK: send 8-bit modulo-256 sum of every byte from count-hi through the last payload byte.
//    After it transfers: frame_done=1 for 1 cycle, frame_cnt+1, go to IDLE.
//  Handshake: tx_data stable while tx_valid=1 && tx_ready=0; tx_valid never drops before transfer.
//    Back-to-back bytes permitted (next byte valid the cycle after transfer).
//  At most one fifo_rdreq is outstanding; no read is issued while a latched word is still unsent.
//  enable deasserted mid-frame: current frame completes; no new frame starts.
//  Word counter is 16 bit; checksum accumulator is 8 bit and wraps silently.
//  Async reset mid-frame: immediate return to reset values; the partial frame is discarded.
// STRUCTURE
//  pos_frame_pkg: HDR0/HDR1 defaults, FRAME_POINTS default, state encoding localparams.
//  Sub-module pos_byte_tx: 4-byte word serializer with valid/ready hold logic, reused for HDR/SEND.
// TESTING
//  1. usedw=811, enable=1, tx_ready=1 -> AA 55 03 2B, 811x4 bytes, checksum; frame_done; cnt=1.
//  2. rddata=32'h1234_0ABC -> bytes 0A BC 12 34; checksum matches the model sum.
//  3. tx_ready toggles 1-of-3 cycles -> tx_data stable while stalled; byte count = 3249.
//  4. usedw=810 -> no rdreq and busy=0; raise usedw to 811 -> frame starts next cycle.
//  5. usedw forced to 0 after 100 words -> frame_err pulse, no checksum, frame_cnt unchanged.
//  6. enable=0 mid-frame -> frame completes; IDLE held even with usedw>=811; rst low mid-frame -> all outputs 0.

Source files
------------

// File: rtl/pos_frame_pkg.sv
// Shared constants, state encoding and helpers for the point-FIFO frame reader.
package pos_frame_pkg;
    localparam int         FRAME_POINTS_DEF = 811;
    localparam int         USEDW_W_DEF      = 11;
    localparam logic [7:0] HDR0_DEF         = 8'hAA;
    localparam logic [7:0] HDR1_DEF         = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RDREQ,
        ST_RDWAIT,
        ST_SEND,
        ST_CHK
    } state_t;

    // Modulo-256 sum of the four bytes of a word.
    function automatic logic [7:0] byte_sum4(input logic [31:0] w);
        return w[31:24] + w[23:16] + w[15:8] + w[7:0];
    endfunction
endpackage

// File: rtl/pos_byte_tx.sv
// Word-to-byte serializer (MSB first) with valid/ready hold; sends last_idx+1 bytes per load.
module pos_byte_tx
    import pos_frame_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
    input  logic [1:0]  last_idx,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        done
);
    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d, last_q, last_d;
    logic        active_q, active_d;
    logic        fire;

    // done must not depend on load: the parent decides its next load from done.
    assign fire = active_q && tx_ready;
    assign done = fire && (idx_q == last_q);

    always_comb begin
        word_d   = word_q;
        idx_d    = idx_q;
        last_d   = last_q;
        active_d = active_q;
        if (load) begin
            word_d   = word;
            idx_d    = 2'd0;
            last_d   = last_idx;
            active_d = 1'b1;
        end else if (fire) begin
            if (idx_q == last_q) active_d = 1'b0;
            else                 idx_d    = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q   <= '0;
            idx_q    <= '0;
            last_q   <= '0;
            active_q <= 1'b0;
        end else begin
            word_q   <= word_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            active_q <= active_d;
        end
    end

    assign tx_valid = active_q;
    assign tx_data  = word_q[{~idx_q, 3'b000} +: 8];
endmodule

// File: rtl/pos_frame_reader.sv
// Drains one buffered scan frame from the point FIFO and emits header/count/payload/checksum bytes.
module pos_frame_reader
    import pos_frame_pkg::*;
#(
    parameter int         FRAME_POINTS = FRAME_POINTS_DEF,
    parameter int         USEDW_W      = USEDW_W_DEF,
    parameter logic [7:0] HDR0         = HDR0_DEF,
    parameter logic [7:0] HDR1         = HDR1_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [USEDW_W-1:0] fifo_usedw,
    output logic               fifo_rdreq,
    input  logic [31:0]        fifo_rddata,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_err,
    output logic [15:0]        frame_cnt
);
    localparam logic [15:0] FP16 = 16'(FRAME_POINTS);

    state_t      state_q, state_d;
    logic [15:0] words_q, words_d, frame_cnt_q, frame_cnt_d;
    logic [7:0]  chk_q, chk_d;
    logic        done_q, done_d, err_q, err_d;
    logic        ld, ser_done;
    logic [31:0] ld_word;
    logic [1:0]  ld_last;

    always_comb begin
        state_d     = state_q;
        words_d     = words_q;
        frame_cnt_d = frame_cnt_q;
        chk_d       = chk_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ld          = 1'b0;
        ld_word     = '0;
        ld_last     = 2'd3;
        fifo_rdreq  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && 32'(fifo_usedw) >= FRAME_POINTS) begin
                    ld      = 1'b1;
                    ld_word = {HDR0, HDR1, FP16};
                    words_d = '0;
                    // checksum covers the count bytes, so seed it with them
                    chk_d   = FP16[15:8] + FP16[7:0];
                    state_d = ST_HDR;
                end
            end
            ST_HDR: if (ser_done) state_d = ST_RDREQ;
            ST_RDREQ: begin
                if (fifo_usedw == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    fifo_rdreq = 1'b1;
                    state_d    = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                ld      = 1'b1;
                // wire order is pos first, then gray
                ld_word = {fifo_rddata[15:0], fifo_rddata[31:16]};
                words_d = words_q + 16'd1;
                chk_d   = chk_q + byte_sum4(fifo_rddata);
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (ser_done) begin
                    if (words_q < FP16) begin
                        state_d = ST_RDREQ;
                    end else begin
                        ld      = 1'b1;
                        ld_word = {chk_q, 24'd0};
                        ld_last = 2'd0;
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (ser_done) begin
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            words_q     <= '0;
            frame_cnt_q <= '0;
            chk_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            words_q     <= words_d;
            frame_cnt_q <= frame_cnt_d;
            chk_q       <= chk_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    pos_byte_tx u_tx (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .word     (ld_word),
        .last_idx (ld_last),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .done     (ser_done)
    );

    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_pos_frame_reader.sv
// Directed bench for pos_frame_reader: FIFO model, byte capture and per-scenario checks.
module tb_pos_frame_reader;
    logic        clk = 1'b0, rst = 1'b0, enable = 1'b0, tx_ready = 1'b0;
    logic [10:0] fifo_usedw = '0;
    logic [31:0] fifo_rddata = '0;
    logic        fifo_rdreq, tx_valid, busy, frame_done, frame_err;
    logic [7:0]  tx_data;
    logic [15:0] frame_cnt;

    int checks = 0, failures = 0;
    int rd_cnt = 0, done_cnt = 0, err_cnt = 0, stall_viol = 0, valid_cyc = 0;
    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    logic       prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = '0;

    always #5 clk = ~clk;

    pos_frame_reader dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_usedw(fifo_usedw),
        .fifo_rdreq(fifo_rdreq), .fifo_rddata(fifo_rddata), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    function automatic logic [31:0] model_word(input int i);
        if (i == 0) return 32'h1234_0ABC;
        return {16'(i * 7 + 256), 16'(i ^ 32'h5A5A)};
    endfunction

    // Monitor, FIFO read model and hold-while-stalled observer, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r && (!tx_valid || tx_data !== prev_d)) stall_viol++;
            if (tx_valid) valid_cyc++;
            if (tx_valid && tx_ready) cap.push_back(tx_data);
            if (fifo_rdreq) begin
                fifo_rddata = model_word(rd_cnt);
                rd_cnt++;
            end
            if (frame_done) done_cnt++;
            if (frame_err) err_cnt++;
            prev_v = tx_valid;
            prev_r = tx_ready;
            prev_d = tx_data;
        end
    end

    task automatic build_exp(input int nwords, input bit with_chk);
        logic [31:0] w;
        logic [7:0]  sum;
        exp_q.delete();
        exp_q.push_back(8'hAA); exp_q.push_back(8'h55);
        exp_q.push_back(8'h03); exp_q.push_back(8'h2B);
        sum = 8'h03 + 8'h2B;
        for (int i = 0; i < nwords; i++) begin
            w = model_word(i);
            exp_q.push_back(w[15:8]);  exp_q.push_back(w[7:0]);
            exp_q.push_back(w[31:24]); exp_q.push_back(w[23:16]);
            sum = sum + w[15:8] + w[7:0] + w[31:24] + w[23:16];
        end
        if (with_chk) exp_q.push_back(sum);
    endtask

    // Runs until a frame_done or frame_err pulse; ready_mode 1 = ready one cycle in three.
    task automatic wait_end(input int ready_mode, input int err_at, output bit timed_out);
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt; timed_out = 1'b1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(posedge clk); #1;
            if (busy) enable = 1'b0;
            tx_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (err_at > 0 && rd_cnt >= err_at) fifo_usedw = '0;
            if (done_cnt != d0 || err_cnt != e0) begin
                timed_out = 1'b0;
                break;
            end
        end
        tx_ready = 1'b1;
    endtask

    task automatic run_frame(input int ready_mode, input int err_at, output bit timed_out);
        cap.delete(); rd_cnt = 0; stall_viol = 0; valid_cyc = 0;
        fifo_usedw = 11'd811; enable = 1'b1;
        wait_end(ready_mode, err_at, timed_out);
    endtask

    task automatic test_reset;
        rst = 1'b0; enable = 1'b0; tx_ready = 1'b1; fifo_usedw = 11'd811;
        repeat (3) @(posedge clk); #1;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (fifo_rdreq !== 1'b0) begin failures++; $display("FAIL reset_rdreq got=%b want=0", fifo_rdreq); end
        checks++; if ({frame_done, frame_err} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b want=00", {frame_done, frame_err}); end
        checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_frame;
        bit to;
        int bad;
        run_frame(0, 0, to);
        build_exp(811, 1'b1);
        checks++; if (to) begin failures++; $display("FAIL frame_timeout got=timeout want=frame_done"); end
        checks++; if (cap.size() != 3249) begin failures++; $display("FAIL frame_len got=%0d want=3249", cap.size()); end
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) if (cap[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL frame_bytes mismatched=%0d want=0", bad); end
        checks++; if (cap.size() > 0 && cap[cap.size()-1] !== exp_q[exp_q.size()-1]) begin failures++; $display("FAIL frame_checksum got=%h want=%h", cap[cap.size()-1], exp_q[exp_q.size()-1]); end
        checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL frame_cnt got=%0d want=1", frame_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL frame_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_byte_order;
        logic [31:0] got;
        got = (cap.size() >= 8) ? {cap[0], cap[1], cap[2], cap[3]} : '0;
        checks++; if (got !== 32'hAA55_032B) begin failures++; $display("FAIL header got=%h want=aa55032b", got); end
        got = (cap.size() >= 8) ? {cap[4], cap[5], cap[6], cap[7]} : '0;
        checks++; if (got !== 32'h0ABC_1234) begin failures++; $display("FAIL first_word_order got=%h want=0abc1234", got); end
    endtask

    task automatic test_stall;
        bit to;
        int bad;
        run_frame(1, 0, to);
        build_exp(811, 1'b1);
        checks++; if (to) begin failures++; $display("FAIL stall_timeout got=timeout want=frame_done"); end
        checks++; if (cap.size() != 3249) begin failures++; $display("FAIL stall_len got=%0d want=3249", cap.size()); end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL stall_hold violations=%0d want=0", stall_viol); end
        checks++; if (valid_cyc <= cap.size()) begin failures++; $display("FAIL stall_exercised valid_cycles=%0d want>%0d", valid_cyc, cap.size()); end
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) if (cap[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL stall_bytes mismatched=%0d want=0", bad); end
        checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL stall_frame_cnt got=%0d want=2", frame_cnt); end
    endtask

    task automatic test_threshold;
        bit to, seen_busy;
        int rd0, v0;
        cap.delete(); rd_cnt = 0; rd0 = rd_cnt; v0 = valid_cyc; seen_busy = 1'b0;
        fifo_usedw = 11'd810; enable = 1'b1; tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        checks++; if (seen_busy || rd_cnt != rd0 || valid_cyc != v0) begin failures++; $display("FAIL below_threshold busy=%b reads=%0d valid=%0d want=0", seen_busy, rd_cnt - rd0, valid_cyc - v0); end
        @(posedge clk); #1; fifo_usedw = 11'd811;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL threshold_same_cycle busy=%b want=0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL threshold_start busy=%b want=1", busy); end
        enable = 1'b0;
        wait_end(0, 0, to);
        checks++; if (to || frame_cnt !== 16'd3) begin failures++; $display("FAIL threshold_frame timeout=%b cnt=%0d want=3", to, frame_cnt); end
    endtask

    task automatic test_underflow;
        bit to;
        int e0, d0, bad;
        e0 = err_cnt; d0 = done_cnt;
        run_frame(0, 100, to);
        build_exp(100, 1'b0);
        checks++; if (to || err_cnt - e0 != 1) begin failures++; $display("FAIL underflow_err timeout=%b pulses=%0d want=1", to, err_cnt - e0); end
        checks++; if (done_cnt != d0) begin failures++; $display("FAIL underflow_done pulses=%0d want=0", done_cnt - d0); end
        checks++; if (rd_cnt != 100) begin failures++; $display("FAIL underflow_reads got=%0d want=100", rd_cnt); end
        checks++; if (cap.size() != 404) begin failures++; $display("FAIL underflow_len got=%0d want=404", cap.size()); end
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) if (cap[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL underflow_bytes mismatched=%0d want=0", bad); end
        checks++; if (frame_cnt !== 16'd3 || busy !== 1'b0) begin failures++; $display("FAIL underflow_state cnt=%0d busy=%b want=3/0", frame_cnt, busy); end
    endtask

    task automatic test_enable_hold;
        bit seen_busy;
        int rd0, v0;
        seen_busy = 1'b0; rd0 = rd_cnt; v0 = valid_cyc;
        enable = 1'b0; fifo_usedw = 11'd811;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        checks++; if (seen_busy || rd_cnt != rd0 || valid_cyc != v0) begin failures++; $display("FAIL enable_hold busy=%b reads=%0d valid=%0d want=0", seen_busy, rd_cnt - rd0, valid_cyc - v0); end
    endtask

    task automatic test_reset_mid;
        int n;
        enable = 1'b1; fifo_usedw = 11'd811; tx_ready = 1'b1; n = 0;
        while (!busy && n < 10) begin @(posedge clk); #1; n++; end
        enable = 1'b0;
        repeat (60) @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midframe_busy got=%b want=1", busy); end
        rst = 1'b0; #1;
        checks++; if ({busy, tx_valid, fifo_rdreq, frame_done, frame_err} !== 5'b0) begin failures++; $display("FAIL async_reset_ctrl got=%b want=00000", {busy, tx_valid, fifo_rdreq, frame_done, frame_err}); end
        checks++; if (tx_data !== 8'h00 || frame_cnt !== 16'd0) begin failures++; $display("FAIL async_reset_data tx_data=%h cnt=%0d want=00/0", tx_data, frame_cnt); end
        #2; rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle busy=%b want=0", busy); end
    endtask

    initial begin
        test_reset;
        test_frame;
        test_byte_order;
        test_stall;
        test_threshold;
        test_underflow;
        test_enable_hold;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
